pixel_plot_sink: RTL and testbench
==================================

Name: pixel_plot_sink

Overview:
- Receiving end of the pixel-plot interface driven by the map and sprite drawers (X, Y, color, plot strobe).
- Buffers plot requests in a small FIFO and clips off-screen coordinates.
- Converts each accepted (X, Y) pair to a linear frame-buffer address and writes it to the 320x240x3 frame-buffer memory port.
- Defers writes while the VGA scan-out side holds the memory, and reports per-frame progress.

Parameters:
- FIFO_DEPTH, 4, plot entries buffered; power of two, at least 2
- SCREEN_W, 320, visible width in pixels
- SCREEN_H, 240, visible height in pixels
- TRANSPARENT_COLOR, 3'b000, color value skipped when the optional feature is enabled

Ports:
- clock  in  1  system clock, all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- plot  in  1  pixel write request, one pixel per cycle
- x  in  9  pixel column
- y  in  8  pixel row
- color  in  3  pixel color {R,G,B}
- ready  out  1  sink can accept a plot this cycle
- scan_busy  in  1  scan-out owns memory this cycle; no write may issue
- frame_start  in  1  one-cycle pulse that clears the frame progress counter
- mem_addr  out  17  frame-buffer write address
- mem_data  out  3  frame-buffer write data
- mem_we  out  1  frame-buffer write enable
- pixel_count  out  17  writes issued since the last frame_start or reset
- frame_complete  out  1  one-cycle pulse when pixel_count reaches SCREEN_W*SCREEN_H

Behaviour:
- Reset (resetn low at a clock edge):
  - FIFO emptied.
  - mem_we=0, mem_addr=0, mem_data=0.
  - pixel_count=0, frame_complete=0.
  - ready is combinational: ready = !full. It reads 1 in the first cycle after reset.
- Accept:
  - A plot is accepted when plot && ready at a rising edge.
  - If x>=SCREEN_W or y>=SCREEN_H, the plot is accepted (handshake completes) but discarded: not pushed, not counted.
  - plot while ready=0 is ignored. The source must hold the request until ready=1.
- FIFO:
  - Count-based, wraparound read and write pointers.
  - Push and pop in the same edge leaves the count unchanged.
  - Push when full is impossible because ready=0 when full.
  - Pop when empty never occurs.
- Issue:
  - In any cycle with FIFO non-empty and scan_busy=0, pop the head entry.
  - At the next edge, register mem_addr = y*320 + x, computed as (y<<8)+(y<<6)+x in 17 bits; maximum value 76799.
  - At the same edge, register mem_data=color and mem_we=1.
  - In any cycle with no pop, mem_we=0 at the next edge. mem_addr and mem_data hold their last values.
- Latency:
  - A plot accepted at edge N, with scan_busy low, produces mem_we=1 in the cycle following edge N+1.
  - This gives a sustained throughput of 1 pixel/clock.
  - scan_busy high stalls pops only. Accepts continue until the FIFO is full.
- Progress counter:
  - pixel_count increments on every edge where mem_we is registered to 1.
  - It saturates at SCREEN_W*SCREEN_H.
  - frame_complete is registered high for exactly one cycle on the increment that reaches SCREEN_W*SCREEN_H. It does not re-fire while saturated.
- frame_start:
  - Clears pixel_count to 0 and suppresses frame_complete.
  - frame_start wins over a simultaneous increment; the concurrent write still issues but is not counted.
  - The FIFO is unaffected.
- Reset mid-operation: queued entries are lost; no partial write is emitted.

Optional Feature:
- Macro PIXEL_SINK_TRANSPARENT_EN.
- When defined:
  - Plots whose color equals TRANSPARENT_COLOR are accepted but discarded at the input, so sprite background pixels leave the frame buffer unchanged.
  - Discarded plots are not counted.
- When undefined: every in-range plot is written regardless of color.

Test Plan:
- Reset then a single plot x=5, y=2, color=3'b101 with scan_busy=0 -> mem_we=1 for one cycle, 2 edges after accept; mem_addr=645; mem_data=3'b101; pixel_count=1.
- Boundary address: plot x=319, y=239 -> mem_addr=76799. Plot x=320, y=0 or x=0, y=240 -> no mem_we, pixel_count unchanged.
- scan_busy held high while 5 consecutive plots are offered -> ready drops after the 4th accept. Release scan_busy -> 4 back-to-back writes in FIFO order, ready rises the cycle after the first pop, 5th plot accepted and written.
- Full-frame raster of 76800 plots, scan_busy=0 -> frame_complete pulses once on the 76800th write; pixel_count holds 76800. A frame_start pulse -> pixel_count=0.
- frame_start coincident with a write -> write issues; pixel_count=0 next cycle. resetn low with 3 entries queued -> mem_we stays 0; ready=1 after reset.
- PIXEL_SINK_TRANSPARENT_EN defined, plots colors 000, 110 -> only the 110 pixel written; pixel_count=1. Undefined -> both written, pixel_count=2.

Source files
------------

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: buffers pixel plot requests, clips off-screen coordinates and writes them
// to the frame buffer. Define PIXEL_SINK_TRANSPARENT_EN to drop plots of TRANSPARENT_COLOR.
module pixel_plot_sink #(
    parameter int         FIFO_DEPTH        = 4,
    parameter int         SCREEN_W          = 320,
    parameter int         SCREEN_H          = 240,
    parameter logic [2:0] TRANSPARENT_COLOR = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [8:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  color,
    output logic        ready,
    input  logic        scan_busy,
    input  logic        frame_start,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    output logic [16:0] pixel_count,
    output logic        frame_complete
);
    localparam int               PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LEVEL   = CNT_W'(FIFO_DEPTH);
    localparam logic [16:0]      FRAME_PIXELS = 17'(SCREEN_W * SCREEN_H);
    localparam logic [9:0]       W_LIMIT      = 10'(SCREEN_W);
    localparam logic [8:0]       H_LIMIT      = 9'(SCREEN_H);

    typedef struct packed {
        logic [2:0] color;
        logic [7:0] y;
        logic [8:0] x;
    } entry_t;

    entry_t             fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   level_r;
    logic               accept_s;
    logic               keep_s;
    logic               push_s;
    logic               pop_s;
    entry_t             head_s;
    logic [16:0]        head_addr_s;

    assign ready = (level_r != FULL_LEVEL);

    // Handshake, clipping, pop decision and head-entry address
    always_comb begin
        accept_s = plot && ready;
        keep_s   = ({1'b0, x} < W_LIMIT) && ({1'b0, y} < H_LIMIT);
`ifdef PIXEL_SINK_TRANSPARENT_EN
        keep_s   = keep_s && (color != TRANSPARENT_COLOR);
`else
        keep_s   = keep_s && 1'b1;
`endif
        push_s   = accept_s && keep_s;
        pop_s    = (level_r != {CNT_W{1'b0}}) && !scan_busy;
        head_s   = fifo_mem_r[rd_ptr_r];
        // For a 320-wide screen this is the (y<<8)+(y<<6)+x shift-add
        head_addr_s = ({9'b0, head_s.y} * 17'(SCREEN_W)) + {8'b0, head_s.x};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + CNT_W'(1);
                2'b01:   level_r <= level_r - CNT_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Entry storage; only slots covered by level_r are ever read, so no reset
    always_ff @(posedge clock) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= '{color: color, y: y, x: x};
        end
    end

    // Frame-buffer write port; address and data hold between writes
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_we   <= 1'b0;
            mem_addr <= 17'd0;
            mem_data <= 3'b000;
        end else if (pop_s) begin
            mem_we   <= 1'b1;
            mem_addr <= head_addr_s;
            mem_data <= head_s.color;
        end else begin
            mem_we   <= 1'b0;
        end
    end

    // Frame progress; frame_start outranks a concurrent increment
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pixel_count    <= 17'd0;
            frame_complete <= 1'b0;
        end else if (frame_start) begin
            pixel_count    <= 17'd0;
            frame_complete <= 1'b0;
        end else if (pop_s && (pixel_count != FRAME_PIXELS)) begin
            pixel_count    <= pixel_count + 17'd1;
            frame_complete <= ((pixel_count + 17'd1) == FRAME_PIXELS);
        end else begin
            frame_complete <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pixel_plot_sink.sv
// Randomized and directed bench for pixel_plot_sink, checked against a queue-based model.
module tb_pixel_plot_sink;
    localparam int DEPTH = 4;
    localparam int W     = 320;
    localparam int H     = 240;
    localparam int FRAME = W * H;

    logic        clock = 1'b0;
    logic        resetn, plot, scan_busy, frame_start;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        ready, mem_we, frame_complete;
    logic [16:0] mem_addr, pixel_count;
    logic [2:0]  mem_data;

    int errors = 0;
    int checks = 0;
    int fc_seen = 0;
    int we_seen = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t q[$];
    int  m_we, m_addr, m_data, m_cnt, m_fc;
    bit  m_valid = 1'b0;

    pixel_plot_sink dut (
        .clock(clock), .resetn(resetn), .plot(plot), .x(x), .y(y), .color(color),
        .ready(ready), .scan_busy(scan_busy), .frame_start(frame_start),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .pixel_count(pixel_count), .frame_complete(frame_complete)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_plot(input bit p, input int xx, input int yy, input int cc);
        plot  = p;
        x     = 9'(xx);
        y     = 8'(yy);
        color = 3'(cc);
    endtask

    // Advance the model over one edge, clock the DUT, then compare everything
    task automatic cycle();
        bit  pop, acc, keep;
        wr_t it;
        if (m_valid) chk("ready", ready, 32'(q.size() < DEPTH));
        if (!resetn) begin
            q.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_fc = 0;
            m_valid = 1'b1;
        end else begin
            pop  = (q.size() > 0) && !scan_busy;
            acc  = plot && (q.size() < DEPTH);
            keep = acc && (int'(x) < W) && (int'(y) < H);
`ifdef PIXEL_SINK_TRANSPARENT_EN
            keep = keep && (color != 3'b000);
`endif
            m_we = pop;
            if (pop) begin
                it = q.pop_front();
                m_addr = it.addr;
                m_data = it.data;
            end
            if (keep) q.push_back('{int'(y) * W + int'(x), int'(color)});
            if (frame_start) begin
                m_cnt = 0; m_fc = 0;
            end else if (pop && m_cnt < FRAME) begin
                m_cnt++;
                m_fc = (m_cnt == FRAME);
            end else begin
                m_fc = 0;
            end
        end
        @(posedge clock);
        #1;
        if (m_valid) begin
            chk("mem_we", mem_we, 32'(m_we));
            chk("mem_addr", mem_addr, 32'(m_addr));
            chk("mem_data", mem_data, 32'(m_data));
            chk("pixel_count", pixel_count, 32'(m_cnt));
            chk("frame_complete", frame_complete, 32'(m_fc));
        end
        if (mem_we === 1'b1) we_seen++;
        if (frame_complete === 1'b1) fc_seen++;
    endtask

    initial begin
        int  idx, w0, f0;
        bit  pre, got;
        resetn = 1'b0; scan_busy = 1'b0; frame_start = 1'b0;
        set_plot(1'b0, 0, 0, 0);
        cycle(); cycle();
        resetn = 1'b1;
        chk("reset_ready", ready, 1);
        chk("reset_we", mem_we, 0);
        chk("reset_count", pixel_count, 0);

        // Single plot: write visible two edges after accept
        set_plot(1'b1, 5, 2, 3'b101);
        cycle();
        set_plot(1'b0, 0, 0, 0);
        chk("single_not_yet", mem_we, 0);
        cycle();
        chk("single_we", mem_we, 1);
        chk("single_addr", mem_addr, 645);
        chk("single_data", mem_data, 3'b101);
        chk("single_count", pixel_count, 1);
        cycle();
        chk("single_we_drop", mem_we, 0);

        // Boundary address and clipped coordinates
        set_plot(1'b1, 319, 239, 3'b011);
        cycle();
        set_plot(1'b1, 320, 0, 3'b111);
        cycle();
        chk("corner_addr", mem_addr, 76799);
        set_plot(1'b1, 0, 240, 3'b111);
        cycle();
        set_plot(1'b0, 0, 0, 0);
        repeat (3) cycle();
        chk("clip_count", pixel_count, 2);

        // Stall with scan_busy: only DEPTH plots fit
        scan_busy = 1'b1;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            set_plot(1'b1, 10 + idx, 20, idx + 1);
            pre = ready;
            cycle();
            if (pre) idx++;
        end
        chk("busy_accepts", idx, 4);
        chk("busy_ready", ready, 0);
        w0 = we_seen;
        scan_busy = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            set_plot(1'b1, 10 + idx, 20, idx + 1);
            pre = ready;
            cycle();
            if (pre) begin
                idx++;
                got = 1'b1;
            end
        end
        chk("fifth_accept", idx, 5);
        set_plot(1'b0, 0, 0, 0);
        repeat (5) cycle();
        chk("busy_writes", we_seen - w0, 5);
        chk("busy_count", pixel_count, 7);

        // frame_start coincident with a write
        set_plot(1'b1, 1, 1, 3'b010);
        cycle();
        set_plot(1'b0, 0, 0, 0);
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        chk("fs_write", mem_we, 1);
        chk("fs_count", pixel_count, 0);
        cycle();

        // Reset with queued entries
        scan_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_plot(1'b1, 30 + k, 3, 3'b001);
            cycle();
        end
        set_plot(1'b0, 0, 0, 0);
        resetn = 1'b0;
        scan_busy = 1'b0;
        w0 = we_seen;
        cycle();
        resetn = 1'b1;
        repeat (4) cycle();
        chk("rst_no_write", we_seen - w0, 0);
        chk("rst_ready", ready, 1);

        // Transparent-color handling
        set_plot(1'b1, 7, 7, 3'b000);
        cycle();
        set_plot(1'b1, 8, 7, 3'b110);
        cycle();
        set_plot(1'b0, 0, 0, 0);
        repeat (3) cycle();
`ifdef PIXEL_SINK_TRANSPARENT_EN
        chk("transp_count", pixel_count, 1);
`else
        chk("transp_count", pixel_count, 2);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            scan_busy   = ($urandom % 4) == 0;
            frame_start = ($urandom % 25) == 0;
            set_plot(($urandom % 3) != 0, $urandom_range(0, 335), $urandom_range(0, 250),
                     $urandom_range(0, 7));
            cycle();
        end
        scan_busy = 1'b0;
        frame_start = 1'b0;
        set_plot(1'b0, 0, 0, 0);
        repeat (6) cycle();

        // Full-frame raster
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        f0 = fc_seen;
        for (int i = 0; i < FRAME; i++) begin
            set_plot(1'b1, i % W, i / W, (i % 7) + 1);
            cycle();
        end
        set_plot(1'b0, 0, 0, 0);
        repeat (4) cycle();
        chk("frame_pulses", fc_seen - f0, 1);
        chk("frame_count", pixel_count, FRAME);
        set_plot(1'b1, 2, 2, 3'b100);
        cycle(); cycle();
        set_plot(1'b0, 0, 0, 0);
        repeat (3) cycle();
        chk("sat_count", pixel_count, FRAME);
        chk("sat_no_refire", fc_seen - f0, 1);
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        chk("frame_clear", pixel_count, 0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
